// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects A/op/B frames from a UART receiver, drives an ALU and streams the result back to a UART transmitter
module uart_alu_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int OPERAND_BYTES  = 1,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               rx_data,
  input  logic                                rx_done,
  input  logic                                tx_done,
  output logic [DATA_WIDTH-1:0]               tx_data,
  output logic                                tx_start,
  output logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_a,
  output logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_b,
  output logic [DATA_WIDTH-1:0]               alu_op,
  input  logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_result,
  output logic                                busy,
  output logic                                err_timeout
);
  localparam int OW = DATA_WIDTH * OPERAND_BYTES;
  localparam int BW = OPERAND_BYTES > 1 ? $clog2(OPERAND_BYTES) : 1;
  localparam int LW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(OPERAND_BYTES - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(ALU_LATENCY - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [2:0] RX_A    = 3'd0;
  localparam logic [2:0] RX_OP   = 3'd1;
  localparam logic [2:0] RX_B    = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] TX_LOAD = 3'd4;
  localparam logic [2:0] TX_WAIT = 3'd5;
  logic [2:0]    state;
  logic [BW-1:0] cnt;
  logic [LW-1:0] lat;
  logic [TW-1:0] tmo;
  logic [OW-1:0] res;
  logic          rx_state;
  logic          accept;
  logic          byte_last;
  logic          exec_done;
  logic          tmo_live;
  logic          expire;
  assign rx_state  = state == RX_A || state == RX_OP || state == RX_B;
  assign accept    = rx_done && rx_state;
  assign byte_last = cnt == BYTE_LAST;
  assign exec_done = state == EXEC && lat == LAT_LAST;
  // an arriving byte always beats an expiring timeout; idle RX_A (busy low) never times out
  assign tmo_live  = TIMEOUT_CYCLES != 0 && busy && rx_state && !rx_done;
  assign expire    = tmo_live && tmo == TMO_LAST;
  // frame sequencing, byte/latency counters, busy flag and timeout abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RX_A;
      cnt         <= '0;
      lat         <= '0;
      tmo         <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= expire;
      tmo         <= tmo_live && !expire ? tmo + 1'b1 : '0;
      if (expire) begin
        state <= RX_A;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          RX_A: if (rx_done) begin
            busy  <= 1'b1;
            cnt   <= byte_last ? '0 : cnt + 1'b1;
            state <= byte_last ? RX_OP : RX_A;
          end
          RX_OP: if (rx_done) state <= RX_B;
          RX_B: if (rx_done) begin
            cnt   <= byte_last ? '0 : cnt + 1'b1;
            state <= byte_last ? EXEC : RX_B;
          end
          EXEC: begin
            lat   <= exec_done ? '0 : lat + 1'b1;
            state <= exec_done ? TX_LOAD : EXEC;
          end
          TX_LOAD: state <= TX_WAIT;
          TX_WAIT: if (tx_done) begin
            cnt   <= byte_last ? '0 : cnt + 1'b1;
            state <= byte_last ? RX_A : TX_LOAD;
            busy  <= !byte_last;
          end
          default: state <= RX_A;
        endcase
      end
    end
  end
  // operand and opcode registers shift in MSB-first and hold outside their accept edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      if (state == RX_A) alu_a <= (alu_a << DATA_WIDTH) | OW'(rx_data);
      if (state == RX_OP) alu_op <= rx_data;
      if (state == RX_B) alu_b <= (alu_b << DATA_WIDTH) | OW'(rx_data);
    end
  end
  // result capture, MSB-first character unload and registered tx strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= state == TX_LOAD;
      if (state == TX_LOAD) tx_data <= res[OW-1 -: DATA_WIDTH];
      if (exec_done) res <= alu_result;
      else if (state == TX_WAIT && tx_done) res <= res << DATA_WIDTH;
    end
  end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: directed and randomized frames against a behavioural model of the sequencer
module tb_uart_alu_sequencer;
  localparam int OB  = 2;
  localparam int LAT = 3;
  localparam int TMO = 40;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  tx_data;
  logic [7:0]  alu_op;
  logic        tx_start;
  logic        busy;
  logic        err_timeout;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [15:0] p1 = 16'h0;
  logic [15:0] p2 = 16'h0;
  logic [15:0] mod_a = 16'h0;
  int          checks = 0;
  int          failures = 0;
  int          err_cnt = 0;
  logic [7:0]  ops [4] = '{8'h20, 8'h2D, 8'h2A, 8'h5E};

  uart_alu_sequencer #(
    .DATA_WIDTH(8), .OPERAND_BYTES(OB), .ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    case (op)
      8'h20:   return a + b;
      8'h2D:   return a - b;
      8'h2A:   return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU with LAT cycles of latency: LAT-1 pipeline stages after the operands settle
  always @(posedge clk) begin
    p1 <= alu_f(alu_a, alu_b, alu_op);
    p2 <= p1;
    if (err_timeout === 1'b1) err_cnt <= err_cnt + 1;
  end
  assign alu_result = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = v;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  function automatic int gp(input int gap);
    return gap < 0 ? int'($urandom_range(0, 6)) : gap;
  endfunction

  task automatic run_frame(input logic [15:0] a, input logic [7:0] op, input logic [15:0] b,
                           input int gap, input bit inj);
    logic [15:0] r;
    logic [7:0]  eb;
    int          k;
    int          w;
    r = alu_f(a, b, op);
    for (int i = OB - 1; i >= 0; i--) send(8'(a >> (8 * i)), gp(gap));
    send(op, gp(gap));
    for (int i = OB - 1; i >= 0; i--) send(8'(b >> (8 * i)), gp(gap));
    mod_a = a;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, op);
    chk("busy_exec", busy, 1);
    for (int j = 0; j < OB; j++) begin
      k = 0;
      do begin
        if (inj && j == 0 && k == 0) tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        k++;
      end while (tx_start !== 1'b1 && k < 64);
      chk("tx_gap", k, j == 0 ? LAT + 1 : 1);
      eb = 8'(r >> (8 * (OB - 1 - j)));
      chk("tx_data", tx_data, eb);
      w = $urandom_range(1, 4);
      for (int c = 0; c < w; c++) begin
        if (inj && j == 0 && c == 0) begin rx_data = 8'hFF; rx_done = 1'b1; end
        @(posedge clk); #1;
        rx_done = 1'b0;
        chk("tx_pulse", tx_start, 0);
        chk("tx_hold", tx_data, eb);
        chk("busy_tx", busy, 1);
      end
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
    chk("busy_end", busy, 0);
  endtask

  task automatic tmo_after(input int n);
    logic [7:0]  v;
    logic [15:0] ea;
    int          k;
    int          e0;
    ea = mod_a;
    e0 = err_cnt;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      send(v, 0);
      if (i < OB) ea = (ea << 8) | 16'(v);
    end
    k = 0;
    while (err_timeout !== 1'b1 && k < TMO + 8) begin @(posedge clk); #1; k++; end
    chk("tmo_lat", k, TMO);
    chk("tmo_busy", busy, 0);
    chk("tmo_alu_a", alu_a, ea);
    @(posedge clk); #1;
    chk("tmo_pulse", err_timeout, 0);
    chk("tmo_count", err_cnt, e0 + 1);
    mod_a = ea;
  endtask

  initial begin
    int k;
    int e0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    repeat (3 * TMO) @(posedge clk);
    #1;
    chk("idle_err", err_cnt, 0);
    chk("idle_busy", busy, 0);
    run_frame(16'h1234, 8'h20, 16'h0101, -1, 1'b0);
    run_frame(16'h0005, 8'h20, 16'h0003, 0, 1'b1);
    run_frame(16'h0007, 8'h20, 16'h0002, 0, 1'b0);
    tmo_after(1);
    run_frame(16'($urandom), ops[$urandom_range(0, 3)], 16'($urandom), -1, 1'b0);
    tmo_after(2 * OB);
    run_frame(16'($urandom), ops[$urandom_range(0, 3)], 16'($urandom), 0, 1'b0);
    e0 = err_cnt;
    run_frame(16'($urandom), ops[$urandom_range(0, 3)], 16'($urandom), TMO - 1, 1'b0);
    chk("edge_byte_wins", err_cnt, e0);
    send(8'hAB, 0); send(8'hCD, 0); send(8'h20, 0); send(8'h11, 0); send(8'h22, 0);
    k = 0;
    while (tx_start !== 1'b1 && k < 64) begin @(posedge clk); #1; k++; end
    chk("pre_rst_start", tx_start, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_start", tx_start, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_alu_op", alu_op, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_timeout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mod_a = 16'h0;
    run_frame(16'h0001, 8'h20, 16'h0001, 0, 1'b0);
    for (int n = 0; n < 15; n++)
      run_frame(16'($urandom), ops[$urandom_range(0, 3)], 16'($urandom), -1, n[0]);
    chk("err_total", err_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Parametrised command sequencer between a UART receiver/transmitter pair and a combinational or pipelined ALU. It collects a frame from the RX side: operand A, opcode, operand B, each operand OPERAND_BYTES wide. It then drives the ALU, waits a fixed latency, and streams the result back through the TX side byte by byte. It adds multi-byte operands, a TX handshake, an inter-byte timeout with error reporting, and a fully synchronous single-clock design with reset.

Parameters:
DATA_WIDTH, 8, width of one UART character and of the opcode
OPERAND_BYTES, 1, characters per operand and per result; minimum 1
ALU_LATENCY, 1, clk cycles from stable operands to valid alu_result; minimum 1
TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
rx_data  input  DATA_WIDTH  received character, valid while rx_done=1
rx_done  input  1  one-cycle strobe in clk domain: rx_data valid
tx_done  input  1  one-cycle strobe: transmitter finished current character
tx_data  output  DATA_WIDTH  character to transmit, held stable until tx_done
tx_start  output  1  one-cycle strobe: start transmitting tx_data
alu_a  output  DATA_WIDTH*OPERAND_BYTES  operand A
alu_b  output  DATA_WIDTH*OPERAND_BYTES  operand B
alu_op  output  DATA_WIDTH  opcode, passed through uninterpreted
alu_result  input  DATA_WIDTH*OPERAND_BYTES  ALU result
busy  output  1  high from the first accepted byte of a frame until the last result byte's tx_done
err_timeout  output  1  one-cycle strobe: frame aborted by timeout

Behaviour:
- Reset (rst_n=0, asynchronous): state RX_A, byte counter 0, timeout counter 0. tx_data, tx_start, alu_a, alu_b, alu_op, busy and err_timeout are all 0. Reset mid-frame or mid-TX aborts immediately; tx_start drops without waiting for tx_done.
- States:
  - RX_A: accepts OPERAND_BYTES characters.
  - RX_OP: accepts 1 character.
  - RX_B: accepts OPERAND_BYTES characters.
  - EXEC: waits ALU_LATENCY cycles.
  - TX_LOAD: issues one character.
  - TX_WAIT: waits for tx_done.
- Byte order: operands and result are MSB-first. The first received character lands in the top DATA_WIDTH bits, and each new character shifts the register left by DATA_WIDTH.
- A byte is accepted on a rising edge where rx_done=1 and the state is RX_A, RX_OP or RX_B. In RX_A and RX_B the byte counter increments; when it reaches OPERAND_BYTES-1, the state advances and the counter clears.
- alu_a, alu_op and alu_b update at the edge that accepts each byte and otherwise hold. They stay stable through EXEC and TX.
- Edge T accepts the last B byte, and the state becomes EXEC. The EXEC counter runs ALU_LATENCY cycles. At edge T+ALU_LATENCY, alu_result is captured into the result shift register and the state becomes TX_LOAD.
- TX_LOAD, for one cycle: the top character of the result register drives tx_data, and tx_start=1. This is registered, so tx_start is high during cycle T+ALU_LATENCY+1. The next state is TX_WAIT.
- TX_WAIT: on tx_done=1, the result register shifts left one character and the counter increments. If more characters remain, the state returns to TX_LOAD; after the last one it goes to RX_A and busy falls. tx_done is honoured only in TX_WAIT and ignored in every other state, including the TX_LOAD cycle.
- rx_done in EXEC, TX_LOAD or TX_WAIT: the character is dropped, with no state change and no error.
- Timeout: active only while busy=1 and the state is RX_A, RX_OP or RX_B. The counter clears on each accepted byte and increments on every other cycle. When it reaches TIMEOUT_CYCLES:
  - err_timeout pulses for 1 cycle;
  - the state returns to RX_A with the counter cleared;
  - busy falls;
  - alu_* registers keep their last values.
- If rx_done and timeout expiry coincide, the byte wins: it is accepted and there is no error.
- The timeout is inactive in RX_A before the first byte, i.e. when idle.
- busy rises on the edge that accepts the first A byte.
- Back-to-back frames: a byte arriving in the cycle after the final tx_done is accepted normally in RX_A.
- Counters are wide enough for OPERAND_BYTES, ALU_LATENCY and TIMEOUT_CYCLES (clog2). The design has no wrap-around at maximum values.

Test Plan:
1. Default params, ALU model result=a+b, latency 1; send 0x05, 0x20, 0x03 -> alu_a=0x05, alu_op=0x20, alu_b=0x03; one tx_start with tx_data=0x08 exactly 2 cycles after the 0x03 rx_done edge; busy falls at tx_done.
2. OPERAND_BYTES=2, ALU_LATENCY=3; send 0x12, 0x34, 0x20, 0x01, 0x01 -> alu_a=0x1234, alu_b=0x0101; tx characters 0x13 then 0x35; the second tx_start appears only after the first tx_done.
3. TIMEOUT_CYCLES=100; send 0x05, then idle 100 cycles -> one err_timeout pulse and busy=0; then send 0x07, 0x20, 0x02 -> tx_data=0x09.
4. Pulse rx_done=0xFF during TX_WAIT and pulse tx_done during EXEC -> both ignored; the result byte is sent once, and the next frame parses correctly.
5. Assert rst_n=0 while tx_start is high in a 2-byte transfer -> all outputs 0 immediately; after release, a fresh frame 0x01, 0x20, 0x01 yields 0x02.
6. rx_done on the exact timeout-expiry cycle (TIMEOUT_CYCLES=50) -> byte accepted, no err_timeout, frame completes.
